// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (load-use, redirect, multi-cycle execute, mem wait-states).
// Optional HAZARD_PERF_EN enables saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int STAGES = 5,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_load,
  input  logic              ex_mc,
  input  logic              mc_done,
  input  logic              ex_jump,
  input  logic              branch_take,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_pause,
  output logic [STAGES-2:0] pipe_pause,
  output logic [STAGES-2:0] pipe_bubble,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  localparam int NP = STAGES - 1;
  localparam int IFID = STAGES - 2;
  localparam int IDEX = STAGES - 3;
  localparam int EXMEM = STAGES - 4;
  localparam logic [NP-1:0] B_IFID = NP'(1) << IFID;
  localparam logic [NP-1:0] B_IDEX = NP'(1) << IDEX;
  localparam logic [NP-1:0] B_EXMEM = NP'(1) << EXMEM;
  localparam logic [NP-1:0] B_LAST = NP'(1);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  state_t r_state, w_next;
  logic w_mem_wait, w_load_use, w_redirect, w_mc_stall;
  assign w_mem_wait = mem_req && !mem_ready;
  assign w_load_use = ex_load && (ex_rd != '0) &&
                      ((rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd));
  assign w_redirect = branch_take || ex_jump;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = (r_state == IDLE) ? ((ex_mc && !mc_done) ? BUSY : IDLE) :
             (r_state == BUSY) ? (mc_done ? (w_mem_wait ? HOLD : IDLE) : BUSY) :
             (w_mem_wait ? HOLD : IDLE);
  end
  // HOLD owns a finished mc result, so only mem_wait can stall there
  always_comb begin
    w_mc_stall = (r_state == IDLE && ex_mc && !mc_done) || (r_state == BUSY && !mc_done);
    pc_pause = 1'b0;
    pipe_pause = '0;
    pipe_bubble = '0;
    if (rst) begin
      pc_pause = 1'b0;
    end else if (w_mem_wait) begin
      pc_pause = 1'b1;
      pipe_pause = ~B_LAST;
      pipe_bubble = B_LAST;
    end else if (w_mc_stall) begin
      pc_pause = 1'b1;
      pipe_pause = B_IFID | B_IDEX;
      pipe_bubble = B_EXMEM;
    end else if (w_load_use) begin
      pc_pause = 1'b1;
      pipe_pause = B_IFID;
      pipe_bubble = B_IDEX;
    end else if (w_redirect) begin
      pipe_bubble = B_IFID | B_IDEX;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall, r_flush;
  logic w_flush;
  assign w_flush = !rst && !pc_pause && w_redirect;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (pc_pause && !(&r_stall)) r_stall <= r_stall + CNT_W'(1);
      if (w_flush && !(&r_flush)) r_flush <= r_flush + CNT_W'(1);
    end
  end
  assign stall_cycles = r_stall;
  assign flush_count = r_flush;
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table vectors plus multi-cycle sequences for hazard_ctrl (STAGES=5).
module tb_hazard_ctrl;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs1, rs2, ex_rd;
  logic rs1_used, rs2_used, ex_load, ex_mc, mc_done, ex_jump, branch_take, mem_req, mem_ready;
  logic pc_pause;
  logic [3:0] pipe_pause, pipe_bubble;
  logic [31:0] stall_cycles, flush_count;
  int checks = 0, failures = 0;
  hazard_ctrl dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_mc(ex_mc), .mc_done(mc_done), .ex_jump(ex_jump),
    .branch_take(branch_take), .mem_req(mem_req), .mem_ready(mem_ready), .pc_pause(pc_pause),
    .pipe_pause(pipe_pause), .pipe_bubble(pipe_bubble), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] rs1, rs2, exrd;
    logic r1u, r2u, ld, mc, dn, jmp, br, mrq, mrd;
    logic [8:0] exp;
  } vec_t;
  vec_t tv[15];
  task automatic chk(input string name, input logic [8:0] exp);
    checks++;
    if ({pc_pause, pipe_pause, pipe_bubble} !== exp) begin
      failures++;
      $display("FAIL %s: got pc_pause=%b pause=%b bubble=%b, want pc_pause=%b pause=%b bubble=%b",
               name, pc_pause, pipe_pause, pipe_bubble, exp[8], exp[7:4], exp[3:0]);
    end
  endtask
  task automatic chk_cnt(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  task automatic clr;
    {rs1, rs2, ex_rd} = '0;
    {rs1_used, rs2_used, ex_load, ex_mc, mc_done, ex_jump, branch_take, mem_req, mem_ready} = '0;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    step();
    rst = 1'b1;
    clr();
    step();
    rst = 1'b0;
  endtask
  task automatic set_lu;
    ex_load = 1'b1;
    ex_rd = 5'd5;
    rs2 = 5'd5;
    rs2_used = 1'b1;
  endtask
  initial begin
    clr();
    tv[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b0_0000_0000};
    tv[1]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 9'b1_1000_0100};
    tv[2]  = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 9'b0_0000_0000};
    tv[3]  = '{5'd0, 5'd5, 5'd5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 9'b0_0000_0000};
    tv[4]  = '{5'd7, 5'd3, 5'd7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 9'b1_1000_0100};
    tv[5]  = '{5'd7, 5'd3, 5'd7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 9'b0_0000_0000};
    tv[6]  = '{5'd7, 5'd3, 5'd7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 9'b0_0000_0000};
    tv[7]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9'b0_0000_1100};
    tv[8]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 9'b0_0000_1100};
    tv[9]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9'b1_1110_0001};
    tv[10] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9'b0_0000_0000};
    tv[11] = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 0, 1, 1, 0, 9'b1_1110_0001};
    tv[12] = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 0, 1, 0, 0, 9'b1_1000_0100};
    tv[13] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 9'b0_0000_1100};
    tv[14] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b0_0000_0000};
    repeat (2) @(posedge clk);
    #1;
    branch_take = 1'b1;
    mem_req = 1'b1;
    set_lu();
    @(negedge clk);
    chk("rst_outputs", 9'b0);
    chk_cnt("rst_stall_cnt", stall_cycles, 32'd0);
    chk_cnt("rst_flush_cnt", flush_count, 32'd0);
    step();
    clr();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rs1 = tv[i].rs1; rs2 = tv[i].rs2; ex_rd = tv[i].exrd;
      rs1_used = tv[i].r1u; rs2_used = tv[i].r2u; ex_load = tv[i].ld;
      ex_mc = tv[i].mc; mc_done = tv[i].dn; ex_jump = tv[i].jmp;
      branch_take = tv[i].br; mem_req = tv[i].mrq; mem_ready = tv[i].mrd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), tv[i].exp);
      step();
    end
    do_reset();
    branch_take = 1'b1;
    @(negedge clk);
    chk("redirect", 9'b0_0000_1100);
    chk_cnt("flush_before", flush_count, 32'd0);
    step();
    branch_take = 1'b0;
    @(negedge clk);
    chk_cnt("flush_after", flush_count, PERF ? 32'd1 : 32'd0);
    chk_cnt("stall_after_redirect", stall_cycles, 32'd0);
    do_reset();
    ex_mc = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mc_stall_c%0d", c), 9'b1_1100_0010);
      step();
    end
    mc_done = 1'b1;
    @(negedge clk);
    chk("mc_release", 9'b0);
    step();
    ex_mc = 1'b0;
    mc_done = 1'b0;
    @(negedge clk);
    chk("mc_after", 9'b0);
    chk_cnt("mc_stall_cnt", stall_cycles, PERF ? 32'd3 : 32'd0);
    step();
    set_lu();
    mem_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("memwait_lu_c%0d", c), 9'b1_1110_0001);
      step();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("lu_after_mem", 9'b1_1000_0100);
    step();
    clr();
    ex_mc = 1'b1;
    @(negedge clk);
    chk("hold_issue", 9'b1_1100_0010);
    step();
    @(negedge clk);
    chk("hold_busy", 9'b1_1100_0010);
    step();
    mc_done = 1'b1;
    mem_req = 1'b1;
    @(negedge clk);
    chk("hold_done_memwait", 9'b1_1110_0001);
    step();
    mc_done = 1'b0;
    @(negedge clk);
    chk("hold_memwait", 9'b1_1110_0001);
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", 9'b0);
    step();
    clr();
    @(negedge clk);
    chk("hold_idle", 9'b0);
    step();
    ex_mc = 1'b1;
    @(negedge clk);
    chk("rstmid_issue", 9'b1_1100_0010);
    step();
    @(negedge clk);
    chk("rstmid_busy", 9'b1_1100_0010);
    step();
    rst = 1'b1;
    mem_req = 1'b1;
    @(negedge clk);
    chk("rstmid_during", 9'b0);
    step();
    rst = 1'b0;
    clr();
    @(negedge clk);
    chk("rstmid_after", 9'b0);
    chk_cnt("rstmid_stall_cnt", stall_cycles, 32'd0);
    chk_cnt("rstmid_flush_cnt", flush_count, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
